// File: rtl/datapath_pkg.sv
// datapath_pkg: shared types and constants for datapath_core.
//   - cmd_op_e : command opcodes on cmd_op
//   - state_e  : command sequencer states
//   - SRC_* / DST_* : bus source / destination offsets, counted from NUM_GPR
package datapath_pkg;

  typedef enum logic [1:0] {
    OP_MOVE   = 2'd0,
    OP_MEM_RD = 2'd1,
    OP_PC_INC = 2'd2,
    OP_NOP    = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Source offsets above the GPR range
  localparam int SRC_HI   = 0;
  localparam int SRC_LO   = 1;
  localparam int SRC_ZHI  = 2;
  localparam int SRC_ZLO  = 3;
  localparam int SRC_PC   = 4;
  localparam int SRC_MDR  = 5;
  localparam int SRC_IN   = 6;
  localparam int SRC_ZERO = 7;

  // Destination offsets above the GPR range
  localparam int DST_HI  = 0;
  localparam int DST_LO  = 1;
  localparam int DST_Y   = 2;
  localparam int DST_MAR = 3;
  localparam int DST_MDR = 4;
  localparam int DST_IR  = 5;
  localparam int DST_PC  = 6;
  localparam int DST_OUT = 7;

  localparam int NUM_SPECIAL = 8;

endpackage

// File: rtl/datapath_core_gpr_file.sv
// gpr_file: NUM_GPR x DATA_W general-purpose register array,
// one synchronous write port and one combinational read port.
// Configuration macro: R0_ZERO_EN -- when defined, GPR0 reads as zero and
// writes to it are silently discarded.
// Ports:
//   clk, clr        clock, synchronous active-high clear (all registers -> 0)
//   we, waddr, wdata write port
//   raddr, rdata    read port
module gpr_file #(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 16,
  parameter int AW      = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs_r [NUM_GPR];
  logic              wr_en_s;

  // Write qualification, including the hard-wired-zero GPR0 option
  always_comb begin
    wr_en_s = 1'b0;
    if (we && (int'(waddr) < NUM_GPR)) begin
`ifdef R0_ZERO_EN
      wr_en_s = (waddr != '0);
`else
      wr_en_s = 1'b1;
`endif
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register array storage with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Combinational read port
  always_comb begin
    rdata = '0;
    if (int'(raddr) >= NUM_GPR) begin
      rdata = '0;
`ifdef R0_ZERO_EN
    end else if (raddr == '0) begin
      rdata = '0;
`endif
    end else begin
      rdata = regs_r[raddr];
    end
  end

endmodule

// File: rtl/datapath_core.sv
// datapath_core: register-transfer datapath with a GPR file, special registers
// (HI, LO, ZHI/ZLO, PC, MDR, MAR, IR, Y, out port) and a single shared bus.
// A command interface performs one-cycle MOVEs, PC increments and handshaked
// memory reads into MDR.
// Configuration macro: R0_ZERO_EN (forwarded to gpr_file; GPR0 hard-wired to 0).
// Ports:
//   clk, clr                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_op, cmd_src, cmd_dst command opcode and bus source/destination indices
//   cmd_err                  one-cycle pulse after a MOVE with an illegal index
//   mem_req, mem_addr        read request (address is MAR)
//   mem_ack, mem_rdata       read response, captured into MDR
//   z_load, z_in             ALU result load into {ZHI,ZLO}, any state
//   in_port                  external input bus source
//   out_port, ir_out, y_out, pc_out  register values
//   bus_out                  current bus value (0 unless a legal MOVE is accepted)
module datapath_core
  import datapath_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_GPR  = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int unsigned       PC_STEP  = 32'd1,
  localparam int               SEL_W    = $clog2(NUM_GPR + 8)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [SEL_W-1:0]      cmd_src,
  input  logic [SEL_W-1:0]      cmd_dst,
  output logic                  cmd_err,
  output logic                  mem_req,
  output logic [DATA_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  z_load,
  input  logic [2*DATA_W-1:0]   z_in,
  input  logic [DATA_W-1:0]     in_port,
  output logic [DATA_W-1:0]     out_port,
  output logic [DATA_W-1:0]     ir_out,
  output logic [DATA_W-1:0]     y_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     bus_out
);

  localparam int               GPR_AW  = $clog2(NUM_GPR);
  // One bit wider so the limit is representable when NUM_GPR+8 is a power of two
  localparam logic [SEL_W:0]   IDX_LIM = (SEL_W + 1)'(NUM_GPR + NUM_SPECIAL);
  localparam logic [SEL_W-1:0] GPR_LIM = SEL_W'(NUM_GPR);

  state_e            state_r, state_nx_s;
  cmd_op_e           op_s;
  logic              accept_s, move_s, idx_ok_s, move_ok_s;
  logic              src_is_gpr_s, dst_is_gpr_s;
  logic [SEL_W-1:0]  src_off_s, dst_off_s;
  logic [DATA_W-1:0] src_val_s, bus_s, gpr_rdata_s;
  logic [DATA_W-1:0] hi_r, lo_r, zhi_r, zlo_r, pc_r, mdr_r, mar_r, ir_r, y_r, out_r;
  logic              err_r;

  assign op_s         = cmd_op_e'(cmd_op);
  assign accept_s     = cmd_valid & cmd_ready;
  assign move_s       = accept_s & (op_s == OP_MOVE);
  assign idx_ok_s     = ({1'b0, cmd_src} < IDX_LIM) && ({1'b0, cmd_dst} < IDX_LIM);
  assign move_ok_s    = move_s & idx_ok_s;
  assign src_is_gpr_s = (cmd_src < GPR_LIM);
  assign dst_is_gpr_s = (cmd_dst < GPR_LIM);
  assign src_off_s    = cmd_src - GPR_LIM;
  assign dst_off_s    = cmd_dst - GPR_LIM;

  gpr_file #(
    .DATA_W  (DATA_W),
    .NUM_GPR (NUM_GPR),
    .AW      (GPR_AW)
  ) u_gpr (
    .clk   (clk),
    .clr   (clr),
    .we    (move_ok_s & dst_is_gpr_s),
    .waddr (cmd_dst[GPR_AW-1:0]),
    .wdata (bus_s),
    .raddr (cmd_src[GPR_AW-1:0]),
    .rdata (gpr_rdata_s)
  );

  // Bus source multiplexer
  always_comb begin
    src_val_s = '0;
    if (src_is_gpr_s) begin
      src_val_s = gpr_rdata_s;
    end else begin
      case (src_off_s)
        SEL_W'(SRC_HI):   src_val_s = hi_r;
        SEL_W'(SRC_LO):   src_val_s = lo_r;
        SEL_W'(SRC_ZHI):  src_val_s = zhi_r;
        SEL_W'(SRC_ZLO):  src_val_s = zlo_r;
        SEL_W'(SRC_PC):   src_val_s = pc_r;
        SEL_W'(SRC_MDR):  src_val_s = mdr_r;
        SEL_W'(SRC_IN):   src_val_s = in_port;
        SEL_W'(SRC_ZERO): src_val_s = '0;
        default:          src_val_s = '0;
      endcase
    end
  end

  // The bus carries data only while a legal MOVE is being accepted
  assign bus_s   = move_ok_s ? src_val_s : '0;
  assign bus_out = bus_s;

  // Special registers, Z pair, PC update, memory capture and error pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      hi_r  <= '0;
      lo_r  <= '0;
      zhi_r <= '0;
      zlo_r <= '0;
      pc_r  <= PC_RESET;
      mdr_r <= '0;
      mar_r <= '0;
      ir_r  <= '0;
      y_r   <= '0;
      out_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (z_load) begin
        {zhi_r, zlo_r} <= z_in;
      end
      if (move_ok_s && !dst_is_gpr_s) begin
        case (dst_off_s)
          SEL_W'(DST_HI):  hi_r  <= bus_s;
          SEL_W'(DST_LO):  lo_r  <= bus_s;
          SEL_W'(DST_Y):   y_r   <= bus_s;
          SEL_W'(DST_MAR): mar_r <= bus_s;
          SEL_W'(DST_MDR): mdr_r <= bus_s;
          SEL_W'(DST_IR):  ir_r  <= bus_s;
          SEL_W'(DST_PC):  pc_r  <= bus_s;
          SEL_W'(DST_OUT): out_r <= bus_s;
          default:         ;
        endcase
      end
      if (accept_s && (op_s == OP_PC_INC)) begin
        pc_r <= pc_r + DATA_W'(PC_STEP);
      end
      // Acks are only meaningful while a read is outstanding
      if ((state_r == ST_MEM_WAIT) && mem_ack) begin
        mdr_r <= mem_rdata;
      end
      err_r <= move_s & ~idx_ok_s;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (op_s == OP_MEM_RD)) begin
          state_nx_s = ST_MEM_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_MEM_WAIT;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Sequencer outputs, decoded from state only
  always_comb begin
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    case (state_r)
      ST_IDLE:     cmd_ready = 1'b1;
      ST_MEM_WAIT: mem_req   = 1'b1;
      default: begin
        cmd_ready = 1'b0;
        mem_req   = 1'b0;
      end
    endcase
  end

  assign cmd_err  = err_r;
  assign mem_addr = mar_r;
  assign out_port = out_r;
  assign ir_out   = ir_r;
  assign y_out    = y_r;
  assign pc_out   = pc_r;

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: stimulus tasks update a behavioural
// model of the register set and queue expected observations with the cycle in
// which they must hold; an independent monitor pops and compares them.
module tb_datapath_core;
  import datapath_pkg::*;

  localparam int DW = 32;
  localparam int NG = 16;
  localparam int SW = 5;

  logic           clk, clr, cmd_valid, cmd_ready, cmd_err, mem_req, mem_ack, z_load;
  logic [1:0]     cmd_op;
  logic [SW-1:0]  cmd_src, cmd_dst;
  logic [DW-1:0]  mem_addr, mem_rdata, in_port, out_port, ir_out, y_out, pc_out, bus_out;
  logic [2*DW-1:0] z_in;

  datapath_core #(.DATA_W(DW), .NUM_GPR(NG)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_err(cmd_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .z_load(z_load), .z_in(z_in), .in_port(in_port), .out_port(out_port),
    .ir_out(ir_out), .y_out(y_out), .pc_out(pc_out), .bus_out(bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  localparam int S_OUT = 0, S_IR = 1, S_Y = 2, S_PC = 3, S_BUS = 4,
                 S_ADDR = 5, S_REQ = 6, S_RDY = 7, S_ERR = 8;
  typedef struct { int due; int sig; logic [31:0] val; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic string sig_name(int s);
    case (s)
      S_OUT: return "out_port";  S_IR: return "ir_out";   S_Y: return "y_out";
      S_PC: return "pc_out";     S_BUS: return "bus_out"; S_ADDR: return "mem_addr";
      S_REQ: return "mem_req";   S_RDY: return "cmd_ready";
      default: return "cmd_err";
    endcase
  endfunction

  function automatic logic [31:0] sig_val(int s);
    case (s)
      S_OUT: return out_port;  S_IR: return ir_out;   S_Y: return y_out;
      S_PC: return pc_out;     S_BUS: return bus_out; S_ADDR: return mem_addr;
      S_REQ: return {31'd0, mem_req};
      S_RDY: return {31'd0, cmd_ready};
      default: return {31'd0, cmd_err};
    endcase
  endfunction

  task automatic push(input int due, input int sig, input logic [31:0] v);
    exp_t e;
    e.due = due; e.sig = sig; e.val = v;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation that has come due, mid-cycle
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        act = sig_val(e.sig);
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d: got %h expected %h", sig_name(e.sig), cyc, act, e.val);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_gpr [NG];
  logic [31:0] m_hi, m_lo, m_zhi, m_zlo, m_pc, m_mdr, m_mar, m_ir, m_y, m_out;

  function automatic logic [31:0] m_read(int idx, logic [31:0] inp);
    if (idx < NG) begin
`ifdef R0_ZERO_EN
      if (idx == 0) return 32'd0;
`endif
      return m_gpr[idx];
    end
    case (idx - NG)
      0: return m_hi;   1: return m_lo;  2: return m_zhi;  3: return m_zlo;
      4: return m_pc;   5: return m_mdr; 6: return inp;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(int idx, logic [31:0] v);
    if (idx < NG) begin
`ifdef R0_ZERO_EN
      if (idx != 0) m_gpr[idx] = v;
`else
      m_gpr[idx] = v;
`endif
    end else begin
      case (idx - NG)
        0: m_hi = v;  1: m_lo = v;  2: m_y = v;   3: m_mar = v;
        4: m_mdr = v; 5: m_ir = v;  6: m_pc = v;  default: m_out = v;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_regs(input int due);
    push(due, S_OUT, m_out); push(due, S_IR, m_ir); push(due, S_Y, m_y);
    push(due, S_PC, m_pc);   push(due, S_ADDR, m_mar);
  endtask

  task automatic do_clr();
    step();
    clr = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_src = 5'd22; cmd_dst = 5'd23;
    in_port = $urandom; z_load = 1'b1; z_in = {$urandom, $urandom}; mem_ack = 1'b0;
    for (int i = 0; i < NG; i++) m_gpr[i] = 32'd0;
    m_hi = 0; m_lo = 0; m_zhi = 0; m_zlo = 0; m_pc = 32'd0; m_mdr = 0;
    m_mar = 0; m_ir = 0; m_y = 0; m_out = 0;
    push(cyc + 1, S_RDY, 32'd1); push(cyc + 1, S_REQ, 32'd0); push(cyc + 1, S_ERR, 32'd0);
    push_regs(cyc + 1);
  endtask

  task automatic idle_step(input logic ack);
    step();
    clr = 1'b0; cmd_valid = 1'b0; z_load = 1'b0; mem_ack = ack; mem_rdata = 32'hAAAA5555;
    push(cyc, S_BUS, 32'd0); push(cyc, S_RDY, 32'd1); push(cyc, S_REQ, 32'd0);
    push(cyc + 1, S_ERR, 32'd0);
    push_regs(cyc + 1);
  endtask

  // One command in IDLE; MEM_RD is completed after 'delay' extra wait cycles
  task automatic issue(input int op, input int src, input int dst, input logic [31:0] inp,
                       input logic zl, input logic [63:0] zv, input int delay,
                       input logic [31:0] rdata);
    logic [31:0] bus_e;
    logic legal, err_e;
    step();
    clr = 1'b0; cmd_valid = 1'b1; cmd_op = 2'(op); cmd_src = SW'(src); cmd_dst = SW'(dst);
    in_port = inp; z_load = zl; z_in = zv;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;  // stray ack, ignored
    legal = (src < NG + 8) && (dst < NG + 8);
    bus_e = 32'd0; err_e = 1'b0;
    if (op == 0) begin
      if (legal) bus_e = m_read(src, inp);
      else err_e = 1'b1;
    end
    push(cyc, S_RDY, 32'd1); push(cyc, S_REQ, 32'd0); push(cyc, S_BUS, bus_e);
    if (op == 0 && legal) m_write(dst, bus_e);
    if (op == 2) m_pc = m_pc + 32'd1;
    if (zl) {m_zhi, m_zlo} = zv;
    push(cyc + 1, S_ERR, {31'd0, err_e});
    push_regs(cyc + 1);
    if (op == 1) begin
      for (int w = 0; w <= delay; w++) begin
        step();
        cmd_valid = 1'b1; cmd_op = 2'd2; z_load = 1'b0;  // must not be accepted
        mem_ack = (w == delay);
        mem_rdata = (w == delay) ? rdata : $urandom;
        push(cyc, S_REQ, 32'd1); push(cyc, S_RDY, 32'd0);
        push(cyc, S_ADDR, m_mar); push(cyc, S_BUS, 32'd0);
      end
      m_mdr = rdata;
      push_regs(cyc + 1);
    end
  endtask

  initial begin
    clr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd3; cmd_src = '0; cmd_dst = '0;
    mem_ack = 1'b0; mem_rdata = '0; z_load = 1'b0; z_in = '0; in_port = '0;

    // Reset state
    do_clr();
    idle_step(1'b0);

    // in_port -> GPR3 -> out_port
    issue(0, 22, 3, 32'hDEADBEEF, 1'b0, 64'd0, 0, 32'd0);
    issue(0, 3, 23, 32'd0, 1'b0, 64'd0, 0, 32'd0);

    // MAR loads, then memory read with a 3-cycle ack delay, then MDR -> out_port
    issue(0, 23, 19, 32'd0, 1'b0, 64'd0, 0, 32'd0);
    issue(0, 20, 19, 32'd0, 1'b0, 64'd0, 0, 32'd0);
    issue(1, 0, 0, 32'd0, 1'b0, 64'd0, 3, 32'h12345678);
    issue(0, 21, 23, 32'd0, 1'b0, 64'd0, 0, 32'd0);

    // PC wrap-around
    issue(0, 22, 22, 32'hFFFFFFFF, 1'b0, 64'd0, 0, 32'd0);
    issue(2, 0, 0, 32'd0, 1'b0, 64'd0, 0, 32'd0);

    // Illegal destination and source indices
    issue(0, 22, NG + 8, 32'h11111111, 1'b0, 64'd0, 0, 32'd0);
    issue(0, 31, 23, 32'h22222222, 1'b0, 64'd0, 0, 32'd0);

    // Z pair load and readback
    issue(3, 0, 0, 32'd0, 1'b1, 64'h0123456789ABCDEF, 0, 32'd0);
    issue(0, 18, 21, 32'd0, 1'b0, 64'd0, 0, 32'd0);
    issue(0, 19, 18, 32'd0, 1'b0, 64'd0, 0, 32'd0);

    // clr during MEM_WAIT, then a stray ack
    step();
    clr = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1; z_load = 1'b0; mem_ack = 1'b0;
    push(cyc, S_RDY, 32'd1); push(cyc, S_REQ, 32'd0); push(cyc, S_BUS, 32'd0);
    step();
    cmd_valid = 1'b0; mem_ack = 1'b0;
    push(cyc, S_REQ, 32'd1); push(cyc, S_RDY, 32'd0);
    do_clr();
    idle_step(1'b1);
    issue(0, 21, 23, 32'd0, 1'b0, 64'd0, 0, 32'd0);

    // GPR0 behaviour (zero register only with R0_ZERO_EN)
    issue(0, 22, 0, 32'd5, 1'b0, 64'd0, 0, 32'd0);
    issue(0, 0, 23, 32'd0, 1'b0, 64'd0, 0, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_clr();
      end else begin
        issue($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31), $urandom,
              1'($urandom_range(0, 3) == 0), {$urandom, $urandom},
              $urandom_range(0, 4), $urandom);
      end
    end

    idle_step(1'b0);
    idle_step(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
